lfsr_rand_gen: RTL and testbench
================================

// Module: lfsr_rand_gen
// PURPOSE
//  Parametrised Galois LFSR with seed load and a request/valid draw port returning a value in [0, range).
//  Draws use a masked rejection-sampling FSM with a bounded fallback.
//  Serves all gameplay randomness: spawn column, produce type, spawn delay.
//  Free-runs every cycle, so the draw result depends on when the request arrives.
// PARAMETERS
//  WIDTH        8      LFSR state width (bits).
//  TAPS         8'hB8  Galois feedback mask, WIDTH bits; default is maximal length (period 255).
//  SEED_DEFAULT 1      State after reset, and the substitute for an all-zero seed; must be nonzero.
//  OUT_W        8      Width of range/value; OUT_W <= WIDTH.
//  MAX_TRIES    4      Rejected candidates allowed before the fallback applies; >= 1.
// PORTS
//  clk    in   1      Clock; all logic on the rising edge.
//  rst    in   1      Reset; synchronous, active-high.
//  seed   in   WIDTH  Seed value, sampled when load=1.
//  load   in   1      Load seed into the LFSR this cycle.
//  req    in   1      Draw request; accepted only when busy=0.
//  range  in   OUT_W  Exclusive upper bound of the draw; sampled with an accepted req.
//  busy   out  1      A draw is in progress.
//  valid  out  1      One-cycle pulse: value is the new result.
//  value  out  OUT_W  Draw result; held until the next valid.
//  q      out  WIDTH  Raw LFSR state.
// BEHAVIOUR
//  Reset: q=SEED_DEFAULT, state IDLE; busy=0, valid=0, value=0. Reset wins over every other input.
//  LFSR step, every cycle unless rst or load: q <= (q>>1) ^ (q[0] ? TAPS : 0).
//  Load: q <= (seed==0) ? SEED_DEFAULT : seed; takes effect next cycle. q can never be all-zero.
//  FSM states: IDLE, DRAW, DONE.
//  IDLE: on req, latch range -> r.
//    - mask = smallest (2^k - 1) >= r-1, where k = clog2(r), computed combinationally from r.
//    - tries = 0; busy=1 from the next cycle; go to DRAW.
//    - req while busy=1 is ignored (not queued).
//  DRAW, each cycle: cand = q[OUT_W-1:0] & mask.
//    - If r==0: value <= 0; go to DONE.
//    - Else if cand < r: value <= cand; go to DONE.
//    - Else if tries == MAX_TRIES-1: value <= cand - r; go to DONE. Because mask < 2r, cand - r < r.
//    - Else tries++ and stay in DRAW.
//  DONE: valid=1 for exactly one cycle, busy=0; go to IDLE. A req in DONE is ignored.
//  Latency from accepted req to valid: min 2 cycles, max MAX_TRIES+1 cycles.
//  load during DRAW: the next candidate comes from the reloaded state; the draw is not aborted.
//  Simultaneous load and req in IDLE: both take effect.
//  Reset mid-draw: returns to IDLE with no valid pulse.
//  range == 1: result is always 0.
// CONFIGURATION
//  Macro LFSR_WRAP_FLAG_EN:
//  - Defined: adds output port wrap (1 bit) and an internal WIDTH-bit register ref.
//    - ref takes the value loaded into q on reset or load.
//    - wrap pulses 1 cycle when a step makes q == ref again, i.e. one full period completed.
//  - Undefined: no wrap port, no ref register; all other behaviour identical.
// STRUCTURE
//  Package lfsr_pkg:
//  - FSM state enum {IDLE, DRAW, DONE}.
//  - Default TAPS constants per width: 8'hB8, 16'hB400, 32'h80200003.
//  - Function mask_for(range) -> smallest all-ones mask >= range-1.
//  Sub-module lfsr_core (clk, rst, load, seed, q):
//  - The stepping register only; reused standalone by the background-noise effects.
//  The top level adds the draw FSM and the optional wrap logic.
// TESTING (default parameters)
//  - Reset 1 cycle, then free-run: q = 8'h01, B8, 5C, 2E, 17, B3 on consecutive cycles.
//  - load=1 with seed=8'h00: q=8'h01 next cycle.
//    load=1 with seed=8'h03: q=8'h03 next cycle, then 8'hB9.
//  - From reset, req with range=1: valid 2 cycles later, value=0, busy high in between.
//    req with range=0: value=0.
//  - 10000 draws with range=6:
//    - every value < 6, and every value 0..5 appears;
//    - latency always in 2..5 cycles;
//    - req asserted while busy causes no extra valid.
//  - rst asserted mid-DRAW: next cycle busy=0, valid=0, q=8'h01, and no valid follows.
//  - LFSR_WRAP_FLAG_EN defined: after reset, wrap first pulses at the cycle where q returns to 8'h01 (255 steps).
//    After load 8'h03: wrap first pulses 255 steps later.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random generator: draw FSM states,
// default feedback masks per width and the rejection-sampling mask helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_e;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    // Maximal-length Galois masks for the supported widths; zero elsewhere.
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = {24'd0, TAPS_W8};
            16:      taps = {16'd0, TAPS_W16};
            32:      taps = TAPS_W32;
            default: taps = 32'd0;
        endcase
        return taps;
    endfunction

    // Smallest all-ones value >= range_v-1: smear the top set bit downwards.
    function automatic logic [31:0] mask_for(input logic [31:0] range_v);
        logic [31:0] m;
        m = (range_v == 32'd0) ? 32'd0 : range_v - 32'd1;
        for (int i = 0; i < 5; i++) begin
            m = m | (m >> (1 << i));
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with seed load; an all-zero seed is replaced by
// SEED_DEFAULT so the register can never lock up.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] feedback;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fb
            assign feedback[gi] = TAPS[gi] & state_q[0];
        end
    endgenerate

    always_comb begin
        state_d = (state_q >> 1) ^ feedback;
        if (load_i) begin
            state_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random source with a request/valid draw port returning a value in
// [0, range). Optional macro LFSR_WRAP_FLAG_EN adds a full-period wrap pulse.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      OUT_W        = 8,
    parameter int unsigned      MAX_TRIES    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             load_i,
    input  logic             req_i,
    input  logic [OUT_W-1:0] range_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [OUT_W-1:0] value_o,
    output logic [WIDTH-1:0] q_o
`ifdef LFSR_WRAP_FLAG_EN
    ,
    output logic             wrap_o
`endif
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    logic [WIDTH-1:0] lfsr_q;
    draw_state_e      state_q, state_d;
    logic [OUT_W-1:0] range_q, range_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_i),
        .seed_i (seed_i),
        .q_o    (lfsr_q)
    );

    assign mask = OUT_W'(mask_for(32'(range_q)));

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_cand
            assign cand[gi] = lfsr_q[gi] & mask[gi];
        end
    endgenerate

    // Since mask < 2*range, cand - range is always a legal fallback result.
    always_comb begin
        state_d = state_q;
        range_d = range_q;
        value_d = value_q;
        tries_d = tries_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    range_d = range_i;
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (range_q == '0) begin
                    value_d = '0;
                    state_d = DONE;
                end else if (cand < range_q) begin
                    value_d = cand;
                    state_d = DONE;
                end else if (tries_q == LAST_TRY) begin
                    value_d = cand - range_q;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            range_q <= '0;
            value_q <= '0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            value_q <= value_d;
            tries_q <= tries_d;
        end
    end

    assign busy_o  = (state_q == DRAW);
    assign valid_o = (state_q == DONE);
    assign value_o = value_q;
    assign q_o     = lfsr_q;

`ifdef LFSR_WRAP_FLAG_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] step_val;
    logic             wrap_q;

    assign step_val = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    // ref_q remembers the state the current period started from.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q  <= SEED_DEFAULT;
            wrap_q <= 1'b0;
        end else if (load_i) begin
            ref_q  <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= (step_val == ref_q);
        end
    end

    assign wrap_o = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: LFSR sequence, seed load, draw timing,
// reset mid-draw and a long range=6 draw run against a small spec model.
module tb_lfsr_rand_gen;

    logic       clk;
    logic       rst;
    logic [7:0] seed;
    logic       load;
    logic       req;
    logic [7:0] range_v;
    logic       busy;
    logic       valid;
    logic [7:0] value;
    logic [7:0] q;
`ifdef LFSR_WRAP_FLAG_EN
    logic       wrap;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_q = 8'h01;

    lfsr_rand_gen dut (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (seed),
        .load_i  (load),
        .req_i   (req),
        .range_i (range_v),
        .busy_o  (busy),
        .valid_o (valid),
        .value_o (value),
        .q_o     (q)
`ifdef LFSR_WRAP_FLAG_EN
        ,
        .wrap_o  (wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic int hand_mask(input int r);
        int m = 0;
        while (m < r - 1) m = m * 2 + 1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model LFSR follows the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst)       m_q = 8'h01;
        else if (load) m_q = (seed == 8'h00) ? 8'h01 : seed;
        else           m_q = lfsr_step(m_q);
        #1;
    endtask

    task automatic draw_check(input logic [7:0] r, input bit hold, output logic [7:0] got_val);
        int exp_val = 0;
        int exp_lat = 0;
        int lat = 0;
        int mk;
        int cand;
        bit got = 0;
        logic [7:0] s;
        s  = m_q;
        mk = hand_mask(int'(r));
        if (r == 8'd0) begin
            exp_val = 0;
            exp_lat = 2;
        end else begin
            for (int t = 0; t < 4 && exp_lat == 0; t++) begin
                s    = lfsr_step(s);
                cand = int'(s) & mk;
                if (cand < int'(r)) begin
                    exp_val = cand;
                    exp_lat = t + 2;
                end else if (t == 3) begin
                    exp_val = cand - int'(r);
                    exp_lat = 5;
                end
            end
        end
        req     = 1'b1;
        range_v = r;
        for (int c = 1; c <= 8 && !got; c++) begin
            tick();
            if (c == 1) req = hold;
            if (valid) begin
                got = 1;
                lat = c;
                req = 1'b0;
            end else begin
                check("busy_in_draw", 32'(busy), 32'd1);
            end
        end
        req = 1'b0;
        check("draw_done", 32'(got), 32'd1);
        got_val = value;
        if (got) begin
            check("draw_latency", lat, exp_lat);
            check("draw_value", 32'(value), exp_val);
            check("busy_at_valid", 32'(busy), 32'd0);
        end
        tick();
        check("no_extra_valid", 32'(valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_seq [6];
        logic [7:0] v;
        logic [5:0] seen;
        exp_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        rst = 1'b1; load = 1'b0; req = 1'b0; seed = 8'h00; range_v = 8'h00;

        // Reset state and free-running sequence.
        tick();
        check("reset_q", 32'(q), 32'h01);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_value", 32'(value), 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 6; i++) begin
            tick();
            check("free_run_q", 32'(q), 32'(exp_seq[i]));
        end

        // Seed loads, including the all-zero substitute.
        seed = 8'h00; load = 1'b1; tick(); load = 1'b0;
        check("load_zero_q", 32'(q), 32'h01);
        seed = 8'h03; load = 1'b1; tick(); load = 1'b0;
        check("load_03_q", 32'(q), 32'h03);
        tick();
        check("load_03_step", 32'(q), 32'hB9);

        // range=1 and range=0 from reset always return 0.
        rst = 1'b1; tick(); rst = 1'b0;
        draw_check(8'd1, 1'b0, v);
        check("range1_value", 32'(v), 32'd0);
        draw_check(8'd0, 1'b0, v);
        check("range0_value", 32'(v), 32'd0);

        // range=200 from reset: first candidate is B8 = 184.
        rst = 1'b1; tick(); rst = 1'b0;
        draw_check(8'd200, 1'b0, v);
        check("range200_value", 32'(v), 32'd184);

        // Simultaneous load and req: candidate comes from the seed 03.
        rst = 1'b1; tick(); rst = 1'b0;
        load = 1'b1; seed = 8'h03; req = 1'b1; range_v = 8'd200;
        tick();
        load = 1'b0; req = 1'b0;
        check("ldreq_busy", 32'(busy), 32'd1);
        check("ldreq_q", 32'(q), 32'h03);
        tick();
        check("ldreq_valid", 32'(valid), 32'd1);
        check("ldreq_value", 32'(value), 32'd3);
        tick();

        // Reset in the middle of a draw.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 1'b1; range_v = 8'd6;
        tick();
        req = 1'b0;
        check("middraw_busy", 32'(busy), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_q", 32'(q), 32'h01);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_valid", 32'(valid), 32'd0);
        end

        // Long range=6 run, req sometimes held high while busy.
        seen = '0;
        for (int n = 0; n < 10000; n++) begin
            draw_check(8'd6, bit'($urandom_range(0, 1)), v);
            check("range6_bound", 32'(v < 8'd6), 32'd1);
            if (v < 8'd6) seen[v[2:0]] = 1'b1;
        end
        check("range6_coverage", 32'(seen), 32'h3F);

`ifdef LFSR_WRAP_FLAG_EN
        begin
            int first;
            rst = 1'b1; tick(); rst = 1'b0;
            first = 0;
            for (int k = 1; k <= 300 && first == 0; k++) begin
                tick();
                if (wrap) first = k;
            end
            check("wrap_reset_steps", first, 255);
            check("wrap_reset_q", 32'(q), 32'h01);
            seed = 8'h03; load = 1'b1; tick(); load = 1'b0;
            check("wrap_load_clear", 32'(wrap), 32'd0);
            first = 0;
            for (int k = 1; k <= 300 && first == 0; k++) begin
                tick();
                if (wrap) first = k;
            end
            check("wrap_load_steps", first, 255);
            check("wrap_load_q", 32'(q), 32'h03);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
